// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// the per-edge action chosen by the PC selector, and default constants.
package fetch_pkg;

    // Default PC / instruction-memory byte-address width.
    localparam int ADDR_W_DEF = 8;

    // Instruction injected into IF/ID on a flush: sll $0,$0,0.
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Fetch FSM. BOOT spends one cycle after reset before fetching starts;
    // HOLD is entered while the hazard unit stalls the front end.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // What the fetch stage does on the coming edge. Decided once, in
    // pc_next_sel, so the PC, IF/ID register and counters all agree.
    typedef enum logic [1:0] {
        ACT_IDLE     = 2'd0,  // BOOT (or illegal state): hold everything
        ACT_REDIRECT = 2'd1,  // load aligned target, flush IF/ID
        ACT_STALL    = 2'd2,  // hold PC and IF/ID
        ACT_FETCH    = 2'd3   // capture instruction, advance PC
    } fetch_act_e;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC selector. Chooses between holding the PC,
// sequential PC+4 and the word-aligned redirect target, and reports which
// action was taken. Priority: BOOT > redirect > stall > normal fetch.
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  fetch_state_e        state,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0]   pc_next,
    output logic [ADDR_W-1:0]   pc_plus4,
    output fetch_act_e          action
);

    logic [ADDR_W-1:0] redirect_aligned;

    // PC arithmetic wraps modulo 2^ADDR_W; the carry out is simply dropped.
    assign pc_plus4 = pc + ADDR_W'(4);

    // Branch/jump targets are forced to a word boundary.
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // Select the action and next PC; stall/redirect are ignored in BOOT.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case/if tree leaves a value unassigned and no latch is inferred.
        action  = ACT_IDLE;
        pc_next = pc;
        case (state)
            RUN, HOLD: begin
                if (redirect) begin
                    action  = ACT_REDIRECT;
                    pc_next = redirect_aligned;
                end else if (stall) begin
                    action  = ACT_STALL;
                end else begin
                    action  = ACT_FETCH;
                    pc_next = pc_plus4;
                end
            end
            default: begin
                // BOOT and the unused encoding hold the PC.
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS32 pipeline. Owns the PC,
// drives the combinational instruction-memory address, holds the IF/ID
// pipeline register and keeps two saturating performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
    parameter int                 CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic [DATA_W-1:0]   imem_data_i,
    output logic [DATA_W-1:0]   ifid_ir_o,
    output logic [ADDR_W-1:0]   ifid_pc_o,
    output logic [ADDR_W-1:0]   ifid_pc4_o,
    output logic                ifid_valid_o,
    output logic [1:0]          fetch_state_o,
    output logic [CNT_W-1:0]    fetch_cnt_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    fetch_act_e        action;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;

    pc_next_sel #(
        .ADDR_W      (ADDR_W)
    ) u_pc_next_sel (
        .state       (state),
        .stall       (stall_i),
        .redirect    (redirect_i),
        .pc          (pc),
        .redirect_pc (redirect_pc_i),
        .pc_next     (pc_next),
        .pc_plus4    (pc_plus4),
        .action      (action)
    );

    // Instruction memory is read combinationally at the current PC.
    assign imem_addr_o   = pc;
    assign fetch_state_o = state;

    // FSM state register; reset always returns to BOOT.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a redirect always lands in RUN, a bare stall in HOLD.
    always_comb begin
        state_next = BOOT;
        case (state)
            BOOT:      state_next = RUN;
            RUN, HOLD: state_next = (stall_i && !redirect_i) ? HOLD : RUN;
            default:   state_next = BOOT;
        endcase
    end

    // PC and IF/ID register; a redirect flushes the instruction but keeps
    // the previous ifid_pc/ifid_pc4 (they are don't-care behind a bubble).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            ifid_ir_o    <= NOP_INSTR;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
        end else begin
            pc <= pc_next;
            case (action)
                ACT_FETCH: begin
                    ifid_ir_o    <= imem_data_i;
                    ifid_pc_o    <= pc;
                    ifid_pc4_o   <= pc_plus4;
                    ifid_valid_o <= 1'b1;
                end
                ACT_REDIRECT: begin
                    ifid_ir_o    <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                end
                default: begin
                    // Stall / BOOT: IF/ID holds.
                end
            endcase
        end
    end

    // Performance counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (action == ACT_FETCH && fetch_cnt_o != '1) begin
                fetch_cnt_o <= fetch_cnt_o + 1'b1;
            end
            if (action == ACT_STALL && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. Stimulus pushes a hand-computed
// expected post-edge snapshot for each vector; a monitor pops and compares
// it against the DUT shortly after each rising edge. A second instance with
// narrow counters exercises counter saturation.
module tb_fetch_stage;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef struct {
        string       name;
        bit          sel;     // 0 = main DUT, 1 = saturation DUT
        logic [7:0]  pc;
        logic [31:0] ir;
        logic [7:0]  ipc;
        logic [7:0]  ipc4;
        logic        valid;
        logic [1:0]  st;
        logic [15:0] fc;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_ir;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pc4;
    logic        ifid_valid;
    logic [1:0]  fetch_state;
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;

    // Instruction memory model: addi $t0,$zero,5 at 0, address-tagged words elsewhere.
    assign imem_data = (imem_addr == 8'h00) ? 32'h2008_0005 : {24'hAB0000, imem_addr};

    fetch_stage u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .ifid_ir_o     (ifid_ir),
        .ifid_pc_o     (ifid_pc),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_valid_o  (ifid_valid),
        .fetch_state_o (fetch_state),
        .fetch_cnt_o   (fetch_cnt),
        .stall_cnt_o   (stall_cnt)
    );

    // Saturation DUT signals (4-bit counters)
    logic        sat_reset = 1'b1;
    logic        sat_stall = 1'b0;
    logic        sat_redirect = 1'b0;
    logic [7:0]  sat_redirect_pc = 8'h00;
    logic [7:0]  sat_addr;
    logic [31:0] sat_data;
    logic [31:0] sat_ir;
    logic [7:0]  sat_ipc;
    logic [7:0]  sat_ipc4;
    logic        sat_valid;
    logic [1:0]  sat_state;
    logic [3:0]  sat_fc;
    logic [3:0]  sat_sc;

    assign sat_data = {24'h000000, sat_addr};

    fetch_stage #(.CNT_W(4)) u_sat (
        .clk           (clk),
        .reset         (sat_reset),
        .stall_i       (sat_stall),
        .redirect_i    (sat_redirect),
        .redirect_pc_i (sat_redirect_pc),
        .imem_addr_o   (sat_addr),
        .imem_data_i   (sat_data),
        .ifid_ir_o     (sat_ir),
        .ifid_pc_o     (sat_ipc),
        .ifid_pc4_o    (sat_ipc4),
        .ifid_valid_o  (sat_valid),
        .fetch_state_o (sat_state),
        .fetch_cnt_o   (sat_fc),
        .stall_cnt_o   (sat_sc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, want);
        end
    endtask

    // Drive one main-DUT vector and queue the expected post-edge snapshot.
    task automatic step(input bit r, input bit s, input bit d, input logic [7:0] rp,
                        input string nm, input logic [7:0] epc, input logic [31:0] eir,
                        input logic [7:0] eipc, input logic [7:0] eipc4, input logic ev,
                        input logic [1:0] est, input int efc, input int esc);
        exp_t e;
        @(negedge clk);
        reset = r; stall = s; redirect = d; redirect_pc = rp;
        e.name = nm; e.sel = 1'b0; e.pc = epc; e.ir = eir; e.ipc = eipc;
        e.ipc4 = eipc4; e.valid = ev; e.st = est; e.fc = 16'(efc); e.sc = 16'(esc);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Drive one saturation-DUT vector and queue its expected snapshot.
    task automatic sat_step(input bit r, input bit s, input string nm,
                            input logic [7:0] epc, input logic [31:0] eir,
                            input logic [7:0] eipc, input logic [7:0] eipc4, input logic ev,
                            input logic [1:0] est, input int efc, input int esc);
        exp_t e;
        @(negedge clk);
        sat_reset = r; sat_stall = s;
        e.name = nm; e.sel = 1'b1; e.pc = epc; e.ir = eir; e.ipc = eipc;
        e.ipc4 = eipc4; e.valid = ev; e.st = est; e.fc = 16'(efc); e.sc = 16'(esc);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    initial begin
        exp_t        e;
        logic [7:0]  a_pc, a_ipc, a_ipc4;
        logic [31:0] a_ir;
        logic        a_v;
        logic [1:0]  a_st;
        logic [15:0] a_fc, a_sc;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vectors++;
                if (!e.sel) begin
                    a_pc = imem_addr; a_ir = ifid_ir; a_ipc = ifid_pc; a_ipc4 = ifid_pc4;
                    a_v = ifid_valid; a_st = fetch_state; a_fc = fetch_cnt; a_sc = stall_cnt;
                end else begin
                    a_pc = sat_addr; a_ir = sat_ir; a_ipc = sat_ipc; a_ipc4 = sat_ipc4;
                    a_v = sat_valid; a_st = sat_state;
                    a_fc = {12'h000, sat_fc}; a_sc = {12'h000, sat_sc};
                end
                check({e.name, ".pc"},        32'(a_pc),   32'(e.pc));
                check({e.name, ".ifid_ir"},   a_ir,        e.ir);
                check({e.name, ".ifid_pc"},   32'(a_ipc),  32'(e.ipc));
                check({e.name, ".ifid_pc4"},  32'(a_ipc4), 32'(e.ipc4));
                check({e.name, ".valid"},     32'(a_v),    32'(e.valid));
                check({e.name, ".state"},     32'(a_st),   32'(e.st));
                check({e.name, ".fetch_cnt"}, 32'(a_fc),   32'(e.fc));
                check({e.name, ".stall_cnt"}, 32'(a_sc),   32'(e.sc));
            end
        end
    end

    // Stimulus
    initial begin
        //    rst s d rpc    name          pc     ir            ipc    ipc4   v  state   fc sc
        // Reset for three cycles, then BOOT for one cycle.
        step(1, 0, 0, 8'h00, "reset0",     8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_BOOT, 0, 0);
        step(1, 0, 0, 8'h00, "reset1",     8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_BOOT, 0, 0);
        step(1, 0, 0, 8'h00, "reset2",     8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_BOOT, 0, 0);
        step(0, 0, 0, 8'h00, "boot",       8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_RUN,  0, 0);
        // First fetch and free run to pc=16.
        step(0, 0, 0, 8'h00, "fetch0",     8'h04, 32'h2008_0005, 8'h00, 8'h04, 1, S_RUN,  1, 0);
        step(0, 0, 0, 8'h00, "fetch4",     8'h08, 32'hAB00_0004, 8'h04, 8'h08, 1, S_RUN,  2, 0);
        step(0, 0, 0, 8'h00, "fetch8",     8'h0C, 32'hAB00_0008, 8'h08, 8'h0C, 1, S_RUN,  3, 0);
        step(0, 0, 0, 8'h00, "fetchC",     8'h10, 32'hAB00_000C, 8'h0C, 8'h10, 1, S_RUN,  4, 0);
        // Stall three cycles at pc=16, then resume.
        step(0, 1, 0, 8'h00, "stall1",     8'h10, 32'hAB00_000C, 8'h0C, 8'h10, 1, S_HOLD, 4, 1);
        step(0, 1, 0, 8'h00, "stall2",     8'h10, 32'hAB00_000C, 8'h0C, 8'h10, 1, S_HOLD, 4, 2);
        step(0, 1, 0, 8'h00, "stall3",     8'h10, 32'hAB00_000C, 8'h0C, 8'h10, 1, S_HOLD, 4, 3);
        step(0, 0, 0, 8'h00, "resume",     8'h14, 32'hAB00_0010, 8'h10, 8'h14, 1, S_RUN,  5, 3);
        // Redirect to 0x43 with stall asserted: aligned to 0x40, flush.
        step(0, 1, 1, 8'h43, "redir43",    8'h40, 32'h0000_0000, 8'h10, 8'h14, 0, S_RUN,  5, 3);
        step(0, 0, 0, 8'h00, "fetch40",    8'h44, 32'hAB00_0040, 8'h40, 8'h44, 1, S_RUN,  6, 3);
        // Redirect out of HOLD to 0xFE -> 0xFC, then PC wrap.
        step(0, 1, 0, 8'h00, "hold44",     8'h44, 32'hAB00_0040, 8'h40, 8'h44, 1, S_HOLD, 6, 4);
        step(0, 1, 1, 8'hFE, "redirFE",    8'hFC, 32'h0000_0000, 8'h40, 8'h44, 0, S_RUN,  6, 4);
        step(0, 0, 0, 8'h00, "wrapFC",     8'h00, 32'hAB00_00FC, 8'hFC, 8'h00, 1, S_RUN,  7, 4);
        step(0, 0, 0, 8'h00, "after_wrap", 8'h04, 32'h2008_0005, 8'h00, 8'h04, 1, S_RUN,  8, 4);
        // Five stall cycles, then reset mid-stall with a redirect pending.
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 8'h00, $sformatf("hold%0d", i),
                 8'h04, 32'h2008_0005, 8'h00, 8'h04, 1, S_HOLD, 8, 4 + i);
        end
        step(1, 1, 1, 8'h80, "reset_hold", 8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_BOOT, 0, 0);
        // stall/redirect are ignored in BOOT.
        step(0, 1, 1, 8'h80, "boot_ign",   8'h00, 32'h0000_0000, 8'h00, 8'h00, 0, S_RUN,  0, 0);
        step(0, 0, 0, 8'h00, "refetch0",   8'h04, 32'h2008_0005, 8'h00, 8'h04, 1, S_RUN,  1, 0);

        // Counter saturation on the 4-bit instance.
        sat_step(1, 0, "sat_reset", 8'h00, 32'h0, 8'h00, 8'h00, 0, S_BOOT, 0, 0);
        sat_step(0, 0, "sat_boot",  8'h00, 32'h0, 8'h00, 8'h00, 0, S_RUN,  0, 0);
        for (int i = 1; i <= 17; i++) begin
            sat_step(0, 1, $sformatf("sat_stall%0d", i),
                     8'h00, 32'h0, 8'h00, 8'h00, 0, S_HOLD, 0, (i > 15) ? 15 : i);
        end
        for (int i = 1; i <= 17; i++) begin
            sat_step(0, 0, $sformatf("sat_fetch%0d", i),
                     8'(4 * i), 32'(4 * (i - 1)), 8'(4 * (i - 1)), 8'(4 * i), 1, S_RUN,
                     (i > 15) ? 15 : i, 15);
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule
